load_store_unit: RTL and testbench

Data-memory access stage of the RV32I single-cycle core, directly downstream of the instruction decoder. It consumes the decoder's memory controls (enable, read/write mode, funct3) together with the ALU effective address and the rs2 value. It runs a req/ack transaction on the data bus, stalling the core until completion. It returns a sign/zero-extended load result for register write-back, or an exception with cause.

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: runs one req/ack bus transaction per load/store,
// stalls the core until it completes, and returns an extended load result or an exception.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_enable,
    input  logic        mem_rw_mode,
    input  logic [2:0]  mem_func,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc,
    output logic [1:0]  exc_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned    CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ALIGN   = 2'b01,
        CAUSE_BUS     = 2'b10,
        CAUSE_TIMEOUT = 2'b11
    } cause_t;

    state_t        state;
    state_t        state_next;
    cause_t        cause_next;
    logic          start;
    logic          finish;
    logic          access_legal;
    logic          timeout_hit;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;
    logic [31:0]   load_ext;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [2:0]    func_q;
    logic [1:0]    lane_q;
    logic [CW-1:0] cnt;

    // Legality: funct3 must exist for the direction, and the address aligned to the access size.
    always_comb begin
        access_legal = 1'b0;
        case (mem_func)
            3'b000:         access_legal = 1'b1;
            3'b001:         access_legal = ~addr[0];
            3'b010:         access_legal = (addr[1:0] == 2'b00);
            3'b100:         access_legal = ~mem_rw_mode;
            3'b101:         access_legal = ~mem_rw_mode & ~addr[0];
            default:        access_legal = 1'b0;
        endcase
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        case (mem_func[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (func_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b101:  load_ext = {16'h0000, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    // Fires on the BUSY cycle whose increment would bring the counter to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        cause_next = CAUSE_NONE;
        case (state)
            IDLE: begin
                if (mem_enable) begin
                    if (access_legal) begin
                        state_next = BUSY;
                        start      = 1'b1;
                    end else begin
                        state_next = DONE;
                        finish     = 1'b1;
                        cause_next = CAUSE_ALIGN;
                    end
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    state_next = DONE;
                    finish     = 1'b1;
                    cause_next = bus_err ? CAUSE_BUS : CAUSE_NONE;
                end else if (timeout_hit) begin
                    state_next = DONE;
                    finish     = 1'b1;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall = (state == BUSY) || ((state == IDLE) && mem_enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            func_q      <= '0;
            lane_q      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            exc         <= 1'b0;
            exc_cause   <= CAUSE_NONE;
        end else begin
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_rw_mode;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be_calc;
                bus_wdata <= wdata_calc;
                func_q    <= mem_func;
                lane_q    <= addr[1:0];
            end
            if (finish) begin
                bus_req     <= 1'b0;
                exc         <= (cause_next != CAUSE_NONE);
                exc_cause   <= cause_next;
                rdata_valid <= (state == BUSY) && !bus_we && (cause_next == CAUSE_NONE);
                if ((state == BUSY) && !bus_we && (cause_next == CAUSE_NONE)) begin
                    rdata <= load_ext;
                end
            end else if (state == DONE) begin
                exc         <= 1'b0;
                exc_cause   <= CAUSE_NONE;
                rdata_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if ((state == BUSY) && !bus_ack && (cnt != '1)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural access model.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_enable = 1'b0;
    logic        mem_rw_mode = 1'b0;
    logic [2:0]  mem_func = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc;
    logic [1:0]  exc_cause;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rdata = '0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_enable(mem_enable), .mem_rw_mode(mem_rw_mode), .mem_func(mem_func),
        .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .exc(exc), .exc_cause(exc_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input bit [2:0] f);
        bit [1:0] s;
        s = f[1:0];
        return 1 << s;
    endfunction

    function automatic bit legal(input bit st, input bit [2:0] f, input bit [31:0] a);
        bit ok_f;
        ok_f = st ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return ok_f && ((a % acc_size(f)) == 0);
    endfunction

    function automatic bit [3:0] model_be(input bit [2:0] f, input bit [31:0] a);
        int sz;
        sz = acc_size(f);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic bit [31:0] model_wdata(input bit [2:0] f, input bit [31:0] wd);
        case (acc_size(f))
            1:       return (wd & 32'hFF) * 32'h01010101;
            2:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic bit [31:0] model_load(input bit [2:0] f, input bit [31:0] a, input bit [31:0] rd);
        longint val;
        longint bits;
        if (acc_size(f) == 4) return rd;
        bits = 8 * acc_size(f);
        val  = (longint'(rd) >> (8 * (a % 4))) & ((64'sd1 << bits) - 1);
        if (f < 3'd4 && val >= (64'sd1 << (bits - 1))) val = val - (64'sd1 << bits);
        return val[31:0];
    endfunction

    // waits < 0 means the slave never acknowledges.
    task automatic do_txn(input bit st, input bit [2:0] f, input bit [31:0] a, input bit [31:0] wd,
                          input int waits, input bit err, input bit [31:0] rd);
        bit lg;
        int n;
        lg = legal(st, f, a);
        mem_enable  = 1'b1;
        mem_rw_mode = st;
        mem_func    = f;
        addr        = a;
        wdata       = wd;
        #1 check("stall_issue", stall, 1);
        @(negedge clk);
        if (!lg) begin
            check("illegal_req", bus_req, 0);
            check("illegal_exc", exc, 1);
            check("illegal_cause", exc_cause, 1);
            check("illegal_valid", rdata_valid, 0);
            check("illegal_stall", stall, 0);
            check("illegal_rdata_hold", rdata, exp_rdata);
        end else begin
            check("busy_req", bus_req, 1);
            check("busy_we", bus_we, st);
            check("busy_addr", bus_addr, {a[31:2], 2'b00});
            check("busy_be", bus_be, model_be(f, a));
            if (st) check("busy_wdata", bus_wdata, model_wdata(f, wd));
            check("busy_stall", stall, 1);
            n = 0;
            while (n < waits) begin
                @(negedge clk);
                check("wait_req", bus_req, 1);
                check("wait_addr_hold", bus_addr, {a[31:2], 2'b00});
                check("wait_stall", stall, 1);
                n++;
            end
            if (waits < 0) begin
                n = 0;
                while (bus_req && n < 3 * TO + 4) begin
                    n++;
                    @(negedge clk);
                end
                check("timeout_req_cycles", n, TO);
                check("timeout_exc", exc, 1);
                check("timeout_cause", exc_cause, 3);
                check("timeout_valid", rdata_valid, 0);
                check("timeout_rdata_hold", rdata, exp_rdata);
            end else begin
                bus_ack   = 1'b1;
                bus_err   = err;
                bus_rdata = rd;
                @(negedge clk);
                bus_ack   = 1'b0;
                bus_err   = 1'b0;
                bus_rdata = $urandom;
                if (!st && !err) exp_rdata = model_load(f, a, rd);
                check("done_valid", rdata_valid, (!st && !err));
                check("done_exc", exc, err);
                check("done_cause", exc_cause, err ? 2 : 0);
                check("done_rdata", rdata, exp_rdata);
                check("done_stall", stall, 0);
                check("done_req", bus_req, 0);
            end
        end
        mem_enable = 1'b0;
        @(negedge clk);
        check("idle_exc", exc, 0);
        check("idle_valid", rdata_valid, 0);
        check("idle_rdata", rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("rst_stall", stall, 0);
        check("rst_req", bus_req, 0);
        check("rst_we", bus_we, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_be", bus_be, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_valid", rdata_valid, 0);
        check("rst_exc", exc, 0);
        check("rst_cause", exc_cause, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, 32'hDEADBEEF);
        check("lw_value", rdata, 32'hDEADBEEF);
        do_txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b0, 32'h80FF0000);
        check("lb_value", rdata, 32'hFFFFFF80);
        do_txn(1'b0, 3'b100, 32'h103, 32'h0, 1, 1'b0, 32'h80FF0000);
        check("lbu_value", rdata, 32'h00000080);
        do_txn(1'b0, 3'b101, 32'h102, 32'h0, 2, 1'b0, 32'h80FF0000);
        check("lhu_value", rdata, 32'h000080FF);
        do_txn(1'b1, 3'b001, 32'h106, 32'h1234ABCD, 0, 1'b0, 32'h0);
        do_txn(1'b0, 3'b010, 32'h102, 32'h0, 0, 1'b0, 32'h0);
        do_txn(1'b1, 3'b011, 32'h100, 32'h0, 0, 1'b0, 32'h0);
        do_txn(1'b0, 3'b010, 32'h200, 32'h0, -1, 1'b0, 32'h0);
        do_txn(1'b0, 3'b010, 32'h204, 32'h0, 1, 1'b1, 32'h55555555);
        do_txn(1'b0, 3'b001, 32'h20A, 32'h0, TO - 1, 1'b0, 32'h8001_7FFE);

        // Reset while BUSY, then a stray ack in IDLE.
        mem_enable  = 1'b1;
        mem_rw_mode = 1'b0;
        mem_func    = 3'b010;
        addr        = 32'h300;
        @(negedge clk);
        check("prerst_req", bus_req, 1);
        mem_enable = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_rst_req", bus_req, 0);
        check("async_rst_rdata", rdata, 0);
        exp_rdata = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("stray_valid", rdata_valid, 0);
        check("stray_exc", exc, 0);
        check("stray_req", bus_req, 0);
        check("stray_stall", stall, 0);
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, 32'hCAFEF00D);

        for (int i = 0; i < 150; i++) begin
            bit [2:0]  f;
            bit [31:0] a;
            int        w;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            w = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(0, TO - 1));
            do_txn(1'($urandom), f, a, $urandom, w, ($urandom_range(0, 5) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
